// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: zeroes itself after reset, accepts a program from a
// loader, then serves pipelined CPU fetches while still allowing loader patches.
module instr_mem_loadable #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_fault,
    input  logic                  load_we,
    input  logic [31:0]           load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  load_ready,
    output logic                  load_ack,
    output logic                  load_err,
    output logic [1:0]            mem_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state;
    logic [AW-1:0]           clear_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    fetch_fire;
    logic                    fetch_bad;
    logic [AW-1:0]           fetch_idx;
    logic                    load_fire;
    logic                    load_bad;
    logic [AW-1:0]           load_idx;

    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_fault;
    logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];

    // A byte address is bad when misaligned or when any bit above the word index is set.
    assign fetch_fire = fetch_req && fetch_ready;
    assign fetch_idx  = fetch_addr[AW+1:2];
    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
    assign load_fire  = load_we && load_ready;
    assign load_idx   = load_addr[AW+1:2];
    assign load_bad   = (load_addr[1:0] != 2'b00) || (load_addr[31:AW+2] != '0);

    assign mem_state   = state;
    assign fetch_valid = pipe_valid[READ_LATENCY-1];
    assign fetch_fault = pipe_fault[READ_LATENCY-1];
    assign fetch_data  = pipe_data[READ_LATENCY-1];

    // NOTE: the array has no reset term so it maps onto RAM; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clock) begin
        if (reset_n && state == ST_CLEAR) begin
            mem[clear_cnt] <= '0;
        end else if (reset_n && load_fire && !load_bad) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_CLEAR;
            clear_cnt   <= '0;
            fetch_ready <= 1'b0;
            load_ready  <= 1'b0;
            load_ack    <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            load_ack <= load_fire && !load_bad;
            load_err <= load_fire && load_bad;
            case (state)
                ST_CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == AW'(DEPTH - 1)) begin
                        state      <= ST_LOAD;
                        load_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (load_done) begin
                        state       <= ST_RUN;
                        fetch_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state       <= ST_CLEAR;
                    clear_cnt   <= '0;
                    fetch_ready <= 1'b0;
                    load_ready  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: non-blocking read and write on the same edge give a colliding fetch the old word.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_fault <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= fetch_fire;
            pipe_fault[0] <= fetch_fire && fetch_bad;
            if (fetch_fire) begin
                pipe_data[0] <= fetch_bad ? '0 : mem[fetch_idx];
            end
            // Data only advances behind a valid entry, so the last stage holds between pulses.
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_fault[i] <= pipe_fault[i-1];
                if (pipe_valid[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable with DEPTH = 16 and READ_LATENCY = 2;
// expected values are hand-computed from the program written by the bench.
module tb_instr_mem_loadable;

    localparam int DW  = 32;
    localparam int DEP = 16;
    localparam int RL  = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_fault;
    logic          load_we;
    logic [31:0]   load_addr;
    logic [DW-1:0] load_data;
    logic          load_done;
    logic          load_ready;
    logic          load_ack;
    logic          load_err;
    logic [1:0]    mem_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    instr_mem_loadable #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEP),
        .READ_LATENCY(RL)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_fault(fetch_fault),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_ready (load_ready),
        .load_ack   (load_ack),
        .load_err   (load_err),
        .mem_state  (mem_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"}, {26'd0, fetch_ready, fetch_valid, fetch_fault,
                               load_ready, load_ack, load_err}, 32'd0);
        check({tag, "_data"}, fetch_data, 32'd0);
        check({tag, "_state"}, {30'd0, mem_state}, 32'd0);
    endtask

    // Counts cycles spent in CLEAR after reset release; bounded so a stuck FSM still ends.
    task automatic wait_clear(input string tag);
        int   cnt  = 0;
        logic seen = 1'b0;
        while (mem_state == 2'd0 && cnt < 100) begin
            seen |= fetch_ready;
            tick();
            cnt++;
        end
        check({tag, "_clear_cycles"}, cnt, 32'd16);
        check({tag, "_clear_fetch_ready"}, {31'd0, seen}, 32'd0);
        check({tag, "_load_state"}, {30'd0, mem_state}, 32'd1);
        check({tag, "_load_ready"}, {31'd0, load_ready}, 32'd1);
    endtask

    task automatic expect_fetch(input string tag, input logic [31:0] data, input logic fault);
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
        check({tag, "_data"}, fetch_data, data);
        check({tag, "_fault"}, {31'd0, fetch_fault}, {31'd0, fault});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");

        // 1: CLEAR length and handshake levels
        reset_n = 1'b1;
        wait_clear("t1");

        // 2: load two words, enter RUN, fetch three words back-to-back
        load_we = 1'b1; load_addr = 32'h00; load_data = 32'h24210001;
        tick();
        check("t2_ack0", {31'd0, load_ack}, 32'd1);
        check("t2_err0", {31'd0, load_err}, 32'd0);
        load_addr = 32'h04; load_data = 32'h24420001;
        tick();
        check("t2_ack1", {31'd0, load_ack}, 32'd1);
        load_we = 1'b0; load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("t2_run_state", {30'd0, mem_state}, 32'd2);
        check("t2_fetch_ready", {31'd0, fetch_ready}, 32'd1);
        check("t2_ack_cleared", {31'd0, load_ack}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h00;
        tick();
        check("t2_lat_not_yet", {31'd0, fetch_valid}, 32'd0);
        fetch_addr = 32'h04;
        tick();
        expect_fetch("t2_f00", 32'h24210001, 1'b0);
        fetch_addr = 32'h08;
        tick();
        expect_fetch("t2_f04", 32'h24420001, 1'b0);
        fetch_req = 1'b0;
        tick();
        expect_fetch("t2_f08", 32'h00000000, 1'b0);
        tick();
        check("t2_valid_drop", {31'd0, fetch_valid}, 32'd0);

        // 3: faulting fetches return zero after a non-zero word; bad load write is dropped
        fetch_req = 1'b1; fetch_addr = 32'h00;
        tick();
        fetch_addr = 32'h06;
        tick();
        expect_fetch("t3_f00", 32'h24210001, 1'b0);
        fetch_addr = 32'h40;
        tick();
        expect_fetch("t3_f06", 32'h00000000, 1'b1);
        fetch_req = 1'b0;
        tick();
        expect_fetch("t3_f40", 32'h00000000, 1'b1);
        tick();
        check("t3_fault_idle", {31'd0, fetch_fault}, 32'd0);
        check("t3_data_hold", fetch_data, 32'h00000000);
        load_we = 1'b1; load_addr = 32'h41; load_data = 32'hFFFFFFFF;
        tick();
        load_we = 1'b0;
        check("t3_err", {31'd0, load_err}, 32'd1);
        check("t3_no_ack", {31'd0, load_ack}, 32'd0);
        fetch_req = 1'b1; fetch_addr = 32'h00;
        tick();
        fetch_req = 1'b0;
        tick();
        expect_fetch("t3_unchanged", 32'h24210001, 1'b0);
        tick();
        check("t3_data_held", fetch_data, 32'h24210001);

        // 4: same-cycle patch and fetch to one word
        load_we = 1'b1; load_addr = 32'h04; load_data = 32'hDEADBEEF;
        fetch_req = 1'b1; fetch_addr = 32'h04;
        tick();
        check("t4_ack", {31'd0, load_ack}, 32'd1);
        load_we = 1'b0;
        tick();
        fetch_req = 1'b0;
        expect_fetch("t4_old", 32'h24420001, 1'b0);
        tick();
        expect_fetch("t4_new", 32'hDEADBEEF, 1'b0);

        // 5: reset with fetches outstanding flushes the pipe and re-clears the array
        fetch_req = 1'b1; fetch_addr = 32'h00;
        tick();
        fetch_addr = 32'h04; reset_n = 1'b0;
        tick();
        fetch_req = 1'b0;
        check("t5_no_valid0", {31'd0, fetch_valid}, 32'd0);
        check_idle_outputs("t5_reset");
        tick();
        check("t5_no_valid1", {31'd0, fetch_valid}, 32'd0);
        reset_n = 1'b1;
        wait_clear("t5");

        // 6: write and load_done together, then read back patched and cleared words
        load_we = 1'b1; load_addr = 32'h08; load_data = 32'h08000003; load_done = 1'b1;
        tick();
        load_we = 1'b0; load_done = 1'b0;
        check("t6_ack", {31'd0, load_ack}, 32'd1);
        check("t6_err", {31'd0, load_err}, 32'd0);
        check("t6_run_state", {30'd0, mem_state}, 32'd2);
        fetch_req = 1'b1; fetch_addr = 32'h08;
        tick();
        fetch_addr = 32'h00;
        tick();
        expect_fetch("t6_f08", 32'h08000003, 1'b0);
        fetch_addr = 32'h04;
        tick();
        fetch_req = 1'b0;
        expect_fetch("t5_f00_cleared", 32'h00000000, 1'b0);
        tick();
        expect_fetch("t5_f04_cleared", 32'h00000000, 1'b0);
        tick();
        check("t6_valid_drop", {31'd0, fetch_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
